mac_aging_table: RTL

//  Parametrised MAC learning/forwarding table for the switch core, one per switch.

---
 rtl/mac_aging_table_pkg.sv | 18 +
 rtl/mat_victim_select.sv | 28 ++
 rtl/mac_aging_table.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mac_aging_table_pkg.sv
// mac_aging_table_pkg: shared entry type, flush FSM states, table geometry and group-address helper
package mac_aging_table_pkg;
  localparam int MAT_NUM_PORTS = 4;
  localparam int MAT_NUM_ENTRIES = 16;
  localparam int MAT_ADDR_W = 48;
  localparam int MAT_AGE_W = 4;
  localparam int MAT_PORT_W = $clog2(MAT_NUM_PORTS);
  typedef struct packed {
    logic valid;
    logic [MAT_ADDR_W-1:0] addr;
    logic [MAT_PORT_W-1:0] port;
    logic [MAT_AGE_W-1:0] age;
  } mat_entry_t;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} flush_state_e;
  function automatic logic is_group_addr(input logic [MAT_ADDR_W-1:0] addr);
    return addr[MAT_ADDR_W-8];
  endfunction
endpackage

// File: rtl/mat_victim_select.sv
// mat_victim_select: picks lowest free entry, else lowest-index entry with the smallest age
module mat_victim_select #(
  parameter int NUM_ENTRIES = 16,
  parameter int AGE_W = 4,
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] valid,
  input  logic [AGE_W-1:0]       age [NUM_ENTRIES],
  output logic                   full,
  output logic [IDX_W-1:0]       idx
);
  logic [IDX_W-1:0] free_idx, vic_idx;
  logic [AGE_W-1:0] min_age;
  always_comb begin
    free_idx = '0;
    vic_idx = '0;
    min_age = age[0];
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) free_idx = valid[i] ? free_idx : IDX_W'(i);
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      if (age[i] < min_age) begin
        min_age = age[i];
        vic_idx = IDX_W'(i);
      end
    end
  end
  assign full = &valid;
  assign idx = full ? vic_idx : free_idx;
endmodule

// File: rtl/mac_aging_table.sv
// mac_aging_table: MAC learn/lookup table with aging, station move, eviction and sweep flush
module mac_aging_table
  import mac_aging_table_pkg::*;
#(
  parameter int NUM_PORTS = MAT_NUM_PORTS,
  parameter int NUM_ENTRIES = MAT_NUM_ENTRIES,
  parameter int ADDR_W = MAT_ADDR_W,
  parameter int AGE_W = MAT_AGE_W,
  localparam int PORT_W = $clog2(NUM_PORTS),
  localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              learn_valid_i,
  output logic              learn_ready_o,
  input  logic [ADDR_W-1:0] learn_addr_i,
  input  logic [PORT_W-1:0] learn_port_i,
  input  logic              lookup_valid_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              lookup_valid_o,
  output logic              lookup_hit_o,
  output logic [PORT_W-1:0] lookup_port_o,
  input  logic              age_tick_i,
  input  logic              flush_req_i,
  input  logic              flush_all_i,
  input  logic [PORT_W-1:0] flush_port_i,
  output logic              flush_done_o,
  output logic              evict_o,
  output logic              move_o,
  output logic [IDX_W:0]    entry_count_o
);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
  mat_entry_t tbl_q [NUM_ENTRIES];
  mat_entry_t tbl_d [NUM_ENTRIES];
  flush_state_e state;
  logic [IDX_W-1:0] sweep_idx, hit_idx, vic_idx, tgt_idx;
  logic [PORT_W-1:0] flush_port_q, hit_port, lk_port;
  logic [NUM_ENTRIES-1:0] valid_vec;
  logic [AGE_W-1:0] age_vec [NUM_ENTRIES];
  logic [IDX_W:0] count_d;
  logic flush_all_q, learn_hit, lk_hit, full, learn_fire, move_d, evict_d;
  always_comb begin
    learn_hit = 1'b0;
    hit_idx = '0;
    hit_port = '0;
    lk_hit = 1'b0;
    lk_port = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      valid_vec[i] = tbl_q[i].valid;
      age_vec[i] = tbl_q[i].age;
      if (tbl_q[i].valid && tbl_q[i].addr == learn_addr_i) begin
        learn_hit = 1'b1;
        hit_idx = IDX_W'(i);
        hit_port = tbl_q[i].port;
      end
      if (tbl_q[i].valid && tbl_q[i].addr == lookup_addr_i) begin
        lk_hit = !is_group_addr(lookup_addr_i);
        lk_port = tbl_q[i].port;
      end
    end
  end
  mat_victim_select #(.NUM_ENTRIES(NUM_ENTRIES), .AGE_W(AGE_W)) u_victim (
    .valid(valid_vec),
    .age  (age_vec),
    .full (full),
    .idx  (vic_idx)
  );
  assign learn_fire = learn_valid_i && learn_ready_o && !is_group_addr(learn_addr_i);
  assign tgt_idx = learn_hit ? hit_idx : vic_idx;
  assign move_d = learn_fire && learn_hit && hit_port != learn_port_i;
  assign evict_d = learn_fire && !learn_hit && full;
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      tbl_d[i] = tbl_q[i];
      if (age_tick_i && tbl_q[i].valid) begin
        tbl_d[i].age = tbl_q[i].age > 1 ? tbl_q[i].age - 1'b1 : '0;
        tbl_d[i].valid = tbl_q[i].age > 1;
      end
      if (state == SWEEP && sweep_idx == IDX_W'(i) && (flush_all_q || tbl_q[i].port == flush_port_q))
        tbl_d[i] = '0;
      if (learn_fire && tgt_idx == IDX_W'(i))
        tbl_d[i] = '{valid: 1'b1, addr: learn_addr_i, port: learn_port_i, age: AGE_MAX};
      count_d = count_d + (IDX_W + 1)'(tbl_d[i].valid);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= '0;
      entry_count_o <= '0;
      lookup_valid_o <= 1'b0;
      lookup_hit_o <= 1'b0;
      lookup_port_o <= '0;
      move_o <= 1'b0;
      evict_o <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= tbl_d[i];
      entry_count_o <= count_d;
      lookup_valid_o <= lookup_valid_i;
      lookup_hit_o <= lookup_valid_i && lk_hit;
      lookup_port_o <= lookup_valid_i && lk_hit ? lk_port : '0;
      move_o <= move_d;
      evict_o <= evict_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sweep_idx <= '0;
      flush_all_q <= 1'b0;
      flush_port_q <= '0;
      flush_done_o <= 1'b0;
      learn_ready_o <= 1'b0;
    end else begin
      flush_done_o <= 1'b0;
      case (state)
        IDLE: begin
          learn_ready_o <= !flush_req_i;
          if (flush_req_i) begin
            state <= SWEEP;
            sweep_idx <= '0;
            flush_all_q <= flush_all_i;
            flush_port_q <= flush_port_i;
          end
        end
        SWEEP: begin
          learn_ready_o <= 1'b0;
          sweep_idx <= sweep_idx + 1'b1;
          if (sweep_idx == IDX_W'(NUM_ENTRIES - 1)) begin
            state <= DONE;
            flush_done_o <= 1'b1;
          end
        end
        DONE: begin
          learn_ready_o <= 1'b1;
          state <= IDLE;
        end
        default: begin
          learn_ready_o <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
